// File: rtl/hilo_unit_if.sv
// EX-stage to HI/LO unit bundle: operation request, MFHI/MFLO read port and stall/status back.
interface hilo_unit_if #(parameter int WIDTH = 32);
    logic             Valid;
    logic [1:0]       HiOp;
    logic [1:0]       LoOp;
    logic             Signed;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             ReadReq;
    logic             ReadHi;
    logic [WIDTH-1:0] ReadData;
    logic [WIDTH-1:0] HiOut;
    logic [WIDTH-1:0] LoOut;
    logic             Busy;
    logic             Stall;

    modport master (
        output Valid, HiOp, LoOp, Signed, A, B, ReadReq, ReadHi,
        input  ReadData, HiOut, LoOut, Busy, Stall
    );

    modport slave (
        input  Valid, HiOp, LoOp, Signed, A, B, ReadReq, ReadHi,
        output ReadData, HiOut, LoOut, Busy, Stall
    );
endinterface

// File: rtl/hilo_unit.sv
// HI/LO register file with iterative shift-add MULT/MULTU/MADD/MSUB; moves take 1 cycle, multiplies 33.
// Requests arriving while a multiply is in flight are ignored and Stall is raised until the unit is idle.
module hilo_unit #(
    parameter int WIDTH = 32
) (
    input  logic       Clk,
    input  logic       Rst,
    hilo_unit_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;
    typedef enum logic [1:0] {OP_MULT, OP_MADD, OP_MSUB} mop_t;

    state_t             state, state_nxt;
    mop_t               op, op_nxt;
    logic [WIDTH-1:0]   hi, lo;
    logic               busy;
    logic               neg;
    logic [WIDTH-1:0]   mplier;
    logic [2*WIDTH-1:0] mcand;
    logic [2*WIDTH-1:0] prod;
    logic [CW-1:0]      cnt;

    logic               is_mthi, is_mtlo, is_mult, is_madd, is_msub;
    logic               accept, start, sign;
    logic [WIDTH-1:0]   abs_a, abs_b;
    logic [2*WIDTH-1:0] prod_s, result;

    assign is_mult = ({bus.HiOp, bus.LoOp} == 4'b0000);
    assign is_mthi = ({bus.HiOp, bus.LoOp} == 4'b0011);
    assign is_mtlo = ({bus.HiOp, bus.LoOp} == 4'b1100);
    assign is_madd = ({bus.HiOp, bus.LoOp} == 4'b0101);
    assign is_msub = ({bus.HiOp, bus.LoOp} == 4'b1010);

    assign accept = bus.Valid && (state == S_IDLE);
    assign start  = accept && (is_mult || is_madd || is_msub);
    assign sign   = bus.Signed & (bus.A[WIDTH-1] ^ bus.B[WIDTH-1]);
    // An unsigned WIDTH-bit magnitude holds 2^(WIDTH-1) exactly, so the most negative operand needs no special case.
    assign abs_a  = (bus.Signed && bus.A[WIDTH-1]) ? -bus.A : bus.A;
    assign abs_b  = (bus.Signed && bus.B[WIDTH-1]) ? -bus.B : bus.B;
    assign op_nxt = is_madd ? OP_MADD : (is_msub ? OP_MSUB : OP_MULT);

    assign prod_s = neg ? -prod : prod;

    always_comb begin
        result = prod_s;
        case (op)
            OP_MADD: result = {hi, lo} + prod_s;
            OP_MSUB: result = {hi, lo} - prod_s;
            default: result = prod_s;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_MUL;
            S_MUL:   if (cnt == CW'(WIDTH - 1)) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) state <= S_IDLE;
        else      state <= state_nxt;
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            hi     <= '0;
            lo     <= '0;
            busy   <= 1'b0;
            op     <= OP_MULT;
            neg    <= 1'b0;
            mplier <= '0;
            mcand  <= '0;
            prod   <= '0;
            cnt    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept && is_mthi) hi <= bus.A;
                    if (accept && is_mtlo) lo <= bus.A;
                    if (start) begin
                        op     <= op_nxt;
                        neg    <= sign;
                        mplier <= abs_a;
                        mcand  <= {{WIDTH{1'b0}}, abs_b};
                        prod   <= '0;
                        cnt    <= '0;
                        busy   <= 1'b1;
                    end
                end
                S_MUL: begin
                    if (mplier[0]) prod <= prod + mcand;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + CW'(1);
                end
                S_DONE: begin
                    {hi, lo} <= result;
                    busy     <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign bus.ReadData = bus.ReadHi ? hi : lo;
    assign bus.HiOut    = hi;
    assign bus.LoOut    = lo;
    assign bus.Busy     = busy;
    assign bus.Stall    = busy & (bus.Valid | bus.ReadReq);
endmodule

// File: tb/tb_hilo_unit.sv
// Scoreboarded bench for hilo_unit: driver pushes expectations from a 64-bit arithmetic model, monitor pops on completions/reads.
module tb_hilo_unit;
    logic Clk = 1'b0;
    logic Rst = 1'b0;
    always #5 Clk = ~Clk;

    hilo_unit_if #(.WIDTH(32)) bus();
    hilo_unit #(.WIDTH(32)) dut (.Clk(Clk), .Rst(Rst), .bus(bus));

    int total = 0;
    int bad   = 0;
    logic [63:0] mulq[$];
    logic [31:0] rdq[$];
    logic [63:0] m = 64'd0;
    time acc_t = 0;
    int  bcnt  = 0;
    logic pb   = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] prod(input logic sg, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb;
        if (sg) begin
            sa = $signed({{32{a[31]}}, a});
            sb = $signed({{32{b[31]}}, b});
            return sa * sb;
        end
        return {32'd0, a} * {32'd0, b};
    endfunction

    task automatic model_apply(input logic [1:0] ho, input logic [1:0] lo_, input logic sg,
                               input logic [31:0] a, input logic [31:0] b);
        case ({ho, lo_})
            4'b0011: m[63:32] = a;
            4'b1100: m[31:0]  = a;
            4'b0000: begin m = prod(sg, a, b);     mulq.push_back(m); end
            4'b0101: begin m = m + prod(sg, a, b); mulq.push_back(m); end
            4'b1010: begin m = m - prod(sg, a, b); mulq.push_back(m); end
            default: ;
        endcase
    endtask

    // Called just after a rising edge; returns just after the edge that accepted the request.
    task automatic issue(input logic [1:0] ho, input logic [1:0] lo_, input logic sg,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic v, input logic rr, input logic rh);
        int n;
        if (rr) rdq.push_back(rh ? m[63:32] : m[31:0]);
        if (v) model_apply(ho, lo_, sg, a, b);
        bus.Valid = v; bus.HiOp = ho; bus.LoOp = lo_; bus.Signed = sg;
        bus.A = a; bus.B = b; bus.ReadReq = rr; bus.ReadHi = rh;
        for (n = 0; n < 200; n++) begin
            @(negedge Clk);
            if (!bus.Stall) break;
        end
        if (n == 200) chk("accept_timeout", 1, 0);
        @(posedge Clk);
        acc_t = $time;
        #1;
        bus.Valid = 1'b0; bus.ReadReq = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        for (n = 0; n < 100; n++) begin
            @(negedge Clk);
            if (!bus.Busy) break;
        end
        if (n == 100) chk("idle_timeout", 1, 0);
        @(posedge Clk); #1;
    endtask

    task automatic mul(input logic [1:0] code, input logic sg, input logic [31:0] a, input logic [31:0] b);
        issue(code, code, sg, a, b, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic mv(input logic hi_sel, input logic [31:0] a);
        if (hi_sel) issue(2'b00, 2'b11, 1'b0, a, 32'd0, 1'b1, 1'b0, 1'b0);
        else        issue(2'b11, 2'b00, 1'b0, a, 32'd0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic rd(input logic rh);
        issue(2'b11, 2'b11, 1'b0, 32'd0, 32'd0, 1'b0, 1'b1, rh);
    endtask

    // Monitor: read data on accepted reads, multiply result and busy length when Busy falls.
    initial begin
        forever begin
            @(negedge Clk);
            if (!Rst) begin
                bcnt = 0; pb = 1'b0;
            end else begin
                if (bus.Valid || bus.ReadReq) chk("stall", bus.Stall, bus.Busy);
                if (bus.ReadReq && !bus.Stall) begin
                    if (rdq.size() == 0) chk("read_unexpected", 1, 0);
                    else                 chk("readdata", bus.ReadData, rdq.pop_front());
                end
                if (bus.Busy) bcnt++;
                else if (pb) begin
                    chk("busy_len", bcnt, 33);
                    if (mulq.size() == 0) chk("mul_unexpected", 1, 0);
                    else                  chk("hilo", {bus.HiOut, bus.LoOut}, mulq.pop_front());
                    bcnt = 0;
                end
                pb = bus.Busy;
            end
        end
    end

    initial begin
        logic [3:0]  code;
        logic [31:0] ra, rb;
        time t0;
        bus.Valid = 0; bus.HiOp = 2'b11; bus.LoOp = 2'b11; bus.Signed = 0;
        bus.A = 0; bus.B = 0; bus.ReadReq = 0; bus.ReadHi = 0;
        #1;
        chk("rst_hi", bus.HiOut, 0);
        chk("rst_lo", bus.LoOut, 0);
        chk("rst_busy", bus.Busy, 0);
        chk("rst_stall", bus.Stall, 0);
        chk("rst_rdata", bus.ReadData, 0);
        repeat (2) @(negedge Clk);
        Rst = 1'b1;
        @(posedge Clk); #1;

        mv(1'b1, 32'hDEADBEEF);
        mv(1'b0, 32'h12345678);
        rd(1'b1);
        rd(1'b0);
        chk("mv_hi", bus.HiOut, 32'hDEADBEEF);
        chk("mv_lo", bus.LoOut, 32'h12345678);
        chk("mv_busy", bus.Busy, 0);

        mul(2'b00, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF);
        wait_idle();
        chk("multu_max", {bus.HiOut, bus.LoOut}, 64'hFFFFFFFE_00000001);
        mul(2'b00, 1'b1, 32'hFFFFFFFD, 32'd5);
        wait_idle();
        chk("mult_neg", {bus.HiOut, bus.LoOut}, 64'hFFFFFFFF_FFFFFFF1);
        mul(2'b00, 1'b1, 32'h80000000, 32'h80000000);
        wait_idle();
        chk("mult_min", {bus.HiOut, bus.LoOut}, 64'h40000000_00000000);

        mv(1'b1, 32'd0);
        mv(1'b0, 32'h10);
        mul(2'b01, 1'b1, 32'd2, 32'd3);
        wait_idle();
        chk("madd", {bus.HiOut, bus.LoOut}, 64'h16);
        mul(2'b10, 1'b1, 32'd4, 32'd4);
        wait_idle();
        chk("msub", {bus.HiOut, bus.LoOut}, 64'h6);
        mv(1'b1, 32'd0);
        mv(1'b0, 32'd0);
        mul(2'b10, 1'b1, 32'd1, 32'd1);
        wait_idle();
        chk("msub_wrap", {bus.HiOut, bus.LoOut}, 64'hFFFFFFFF_FFFFFFFF);

        // Hazard: MTHI and MFLO held against an in-flight MULT
        mul(2'b00, 1'b1, $urandom, $urandom);
        issue(2'b00, 2'b11, 1'b0, 32'h5, 32'd0, 1'b1, 1'b1, 1'b0);
        rd(1'b1);
        chk("hazard_hi", bus.HiOut, 32'h5);

        mul(2'b00, 1'b0, $urandom, $urandom);
        t0 = acc_t;
        mul(2'b00, 1'b1, $urandom, $urandom);
        chk("ii", (acc_t - t0) / 10, 34);

        for (int i = 0; i < 24; i++) begin
            ra = $urandom; rb = $urandom;
            if (i % 4 == 0) ra = {$urandom_range(0, 1) ? 2'b10 : 2'b01, 30'd0};
            case ($urandom_range(0, 6))
                0: mul(2'b00, 1'($urandom_range(0, 1)), ra, rb);
                1: mul(2'b01, 1'($urandom_range(0, 1)), ra, rb);
                2: mul(2'b10, 1'($urandom_range(0, 1)), ra, rb);
                3: mv(1'b1, ra);
                4: mv(1'b0, ra);
                5: begin
                    code = 4'($urandom_range(0, 15));
                    if (code == 4'b0000 || code == 4'b0011 || code == 4'b1100 ||
                        code == 4'b0101 || code == 4'b1010) code = 4'b1111;
                    issue(code[3:2], code[1:0], 1'b1, ra, rb, 1'b1, 1'b0, 1'b0);
                end
                default: rd(1'($urandom_range(0, 1)));
            endcase
        end
        rd(1'b1);
        rd(1'b0);
        wait_idle();
        chk("final_model", {bus.HiOut, bus.LoOut}, m);

        // Reset at multiply counter 10: operation abandoned, no late write
        mv(1'b1, 32'hA5A5A5A5);
        mul(2'b00, 1'b0, 32'h1234, 32'h5678);
        repeat (10) @(posedge Clk);
        #1;
        bus.Valid = 1'b1; bus.HiOp = 2'b11; bus.LoOp = 2'b11;
        Rst = 1'b0;
        mulq.delete(); rdq.delete(); m = 64'd0;
        #1;
        chk("mrst_hi", bus.HiOut, 0);
        chk("mrst_lo", bus.LoOut, 0);
        chk("mrst_busy", bus.Busy, 0);
        chk("mrst_stall", bus.Stall, 0);
        bus.Valid = 1'b0;
        repeat (2) @(negedge Clk);
        Rst = 1'b1;
        repeat (40) @(posedge Clk);
        #1;
        chk("post_rst_hilo", {bus.HiOut, bus.LoOut}, 0);
        chk("post_rst_busy", bus.Busy, 0);
        chk("mulq_empty", mulq.size(), 0);
        chk("rdq_empty", rdq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
